// File: rtl/team_06_pkg.sv
// Shared types and constants for the team_06 audio output path.
// Holds the sample buffer state encoding and the audio midscale code.
package team_06_pkg;

  localparam int SAMPLE_W = 8;
  localparam logic [SAMPLE_W-1:0] AUDIO_MIDSCALE = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } buf_state_t;

  // Counter width that stays legal when a modulus of 1 is requested.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/team_06_sync_fifo.sv
// Single-clock FIFO with registered storage and wrap-bit pointers.
// Occupancy is the pointer difference, so full/empty need no extra state.
module team_06_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // A refused push or pop leaves pointers and storage untouched.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/team_06_dac_sample_buffer.sv
// Paced sample buffer feeding the I2S serializer: one FIFO pop per word
// period of bit_tick pulses, midscale on idle/underrun, re-prime after underrun.
module team_06_dac_sample_buffer
  import team_06_pkg::*;
#(
  parameter int                 WIDTH         = SAMPLE_W,
  parameter int                 DEPTH         = 8,
  parameter int                 BITS_PER_WORD = 8,
  parameter int                 FILL_THRESH   = 4,
  parameter logic [WIDTH-1:0]   IDLE_VALUE    = AUDIO_MIDSCALE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   bit_tick,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [WIDTH-1:0]       parallel_out,
  output logic                   sample_strobe,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] level
);

  localparam int                LVL_W    = $clog2(DEPTH) + 1;
  localparam int                CNT_W    = cnt_width(BITS_PER_WORD);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BITS_PER_WORD - 1);
  localparam logic [LVL_W-1:0]  THRESH   = LVL_W'(FILL_THRESH);

  buf_state_t       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             strobe_q, strobe_d;
  logic             underrun_q, underrun_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic             boundary;

  // wr_ready comes straight from registered occupancy, so a pop in the
  // same cycle never opens a slot for a push while full.
  assign wr_ready  = !fifo_full;
  assign fifo_push = wr_valid && wr_ready;
  assign boundary  = bit_tick && (bit_cnt_q == CNT_LAST);

  team_06_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    out_d      = out_q;
    strobe_d   = 1'b0;
    underrun_d = 1'b0;
    fifo_pop   = 1'b0;

    if (!en) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      out_d     = IDLE_VALUE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = FILL;
          bit_cnt_d = '0;
          out_d     = IDLE_VALUE;
        end
        FILL: begin
          bit_cnt_d = '0;
          out_d     = IDLE_VALUE;
          if (fifo_level >= THRESH) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (bit_tick) begin
            bit_cnt_d = boundary ? '0 : bit_cnt_q + CNT_W'(1);
          end
          if (boundary) begin
            strobe_d = 1'b1;
            if (fifo_empty) begin
              // Starved: emit midscale and wait for a fresh prime.
              out_d      = IDLE_VALUE;
              underrun_d = 1'b1;
              state_d    = FILL;
            end else begin
              fifo_pop = 1'b1;
              out_d    = fifo_head;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          out_d     = IDLE_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      out_q      <= IDLE_VALUE;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      out_q      <= out_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  assign parallel_out  = out_q;
  assign sample_strobe = strobe_q;
  assign underrun      = underrun_q;
  assign level         = fifo_level;

endmodule

// File: tb/tb_team_06_dac_sample_buffer.sv
// Directed bench for team_06_dac_sample_buffer: priming, paced playback,
// full FIFO, underrun, disable/reset and simultaneous push/pop.
module tb_team_06_dac_sample_buffer;
  import team_06_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       bit_tick;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] parallel_out;
  logic       sample_strobe;
  logic       underrun;
  logic [3:0] level;

  int n_checks     = 0;
  int n_pass       = 0;
  int strobe_cnt   = 0;
  int underrun_cnt = 0;

  team_06_dac_sample_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .bit_tick      (bit_tick),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .parallel_out  (parallel_out),
    .sample_strobe (sample_strobe),
    .underrun      (underrun),
    .level         (level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sample_strobe === 1'b1) strobe_cnt++;
    if (underrun === 1'b1) underrun_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic tick(input int gap);
    bit_tick = 1'b1;
    step();
    bit_tick = 1'b0;
    repeat (gap - 1) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; bit_tick = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    step();
    n_checks++; if (parallel_out !== 8'h80) $display("FAIL reset_out: got %h want 80", parallel_out); else n_pass++;
    n_checks++; if (sample_strobe !== 1'b0) $display("FAIL reset_strobe: got %b want 0", sample_strobe); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else n_pass++;
    n_checks++; if (level !== 4'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
    n_checks++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %b want 1", wr_ready); else n_pass++;
    n_checks++; if (dut.state_q !== IDLE) $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE); else n_pass++;
  endtask

  task automatic test_priming();
    int s0;
    en = 1'b1;
    step();
    n_checks++; if (dut.state_q !== FILL) $display("FAIL prime_enter_fill: got %0d want %0d", dut.state_q, FILL); else n_pass++;
    push(8'h11); push(8'h22); push(8'h33);
    n_checks++; if (parallel_out !== 8'h80) $display("FAIL prime_out_idle: got %h want 80", parallel_out); else n_pass++;
    n_checks++; if (dut.state_q !== FILL) $display("FAIL prime_still_fill: got %0d want %0d", dut.state_q, FILL); else n_pass++;
    n_checks++; if (level !== 4'd3) $display("FAIL prime_level3: got %0d want 3", level); else n_pass++;
    push(8'h44);
    step();
    n_checks++; if (dut.state_q !== RUN) $display("FAIL prime_run: got %0d want %0d", dut.state_q, RUN); else n_pass++;
    s0 = strobe_cnt;
    repeat (7) tick(1);
    n_checks++; if (parallel_out !== 8'h80) $display("FAIL prime_pre_boundary: got %h want 80", parallel_out); else n_pass++;
    n_checks++; if (strobe_cnt !== s0) $display("FAIL prime_no_early_strobe: got %0d want %0d", strobe_cnt, s0); else n_pass++;
    tick(1);
    n_checks++; if (parallel_out !== 8'h11) $display("FAIL prime_first_word: got %h want 11", parallel_out); else n_pass++;
    n_checks++; if (sample_strobe !== 1'b1) $display("FAIL prime_strobe_hi: got %b want 1", sample_strobe); else n_pass++;
    n_checks++; if (level !== 4'd3) $display("FAIL prime_level_after_pop: got %0d want 3", level); else n_pass++;
    step();
    n_checks++; if (sample_strobe !== 1'b0) $display("FAIL prime_strobe_lo: got %b want 0", sample_strobe); else n_pass++;
    n_checks++; if (strobe_cnt !== s0 + 1) $display("FAIL prime_one_strobe: got %0d want %0d", strobe_cnt, s0 + 1); else n_pass++;
  endtask

  task automatic test_steady();
    logic [7:0] lead [3];
    logic [7:0] prev, exp;
    int u0, s0;
    lead = '{8'h22, 8'h33, 8'h44};
    prev = 8'h11;
    u0 = underrun_cnt;
    s0 = strobe_cnt;
    for (int i = 0; i < 16; i++) begin
      push(8'(i + 1));
      repeat (22) step();
      repeat (7) tick(24);
      n_checks++; if (parallel_out !== prev) $display("FAIL steady_hold%0d: got %h want %h", i, parallel_out, prev); else n_pass++;
      exp = (i < 3) ? lead[i] : 8'(i - 2);
      tick(1);
      n_checks++; if (parallel_out !== exp) $display("FAIL steady_word%0d: got %h want %h", i, parallel_out, exp); else n_pass++;
      prev = exp;
    end
    step();
    n_checks++; if (underrun_cnt !== u0) $display("FAIL steady_no_underrun: got %0d want %0d", underrun_cnt, u0); else n_pass++;
    n_checks++; if (strobe_cnt !== s0 + 16) $display("FAIL steady_strobes: got %0d want %0d", strobe_cnt, s0 + 16); else n_pass++;
    n_checks++; if (level !== 4'd3) $display("FAIL steady_level: got %0d want 3", level); else n_pass++;
  endtask

  task automatic test_underrun();
    logic [7:0] drain [3];
    int u0;
    drain = '{8'h0E, 8'h0F, 8'h10};
    u0 = underrun_cnt;
    for (int i = 0; i < 3; i++) begin
      repeat (8) tick(1);
      n_checks++; if (parallel_out !== drain[i]) $display("FAIL under_drain%0d: got %h want %h", i, parallel_out, drain[i]); else n_pass++;
    end
    repeat (7) tick(1);
    tick(1);
    n_checks++; if (parallel_out !== 8'h80) $display("FAIL under_out: got %h want 80", parallel_out); else n_pass++;
    n_checks++; if (underrun !== 1'b1) $display("FAIL under_pulse: got %b want 1", underrun); else n_pass++;
    n_checks++; if (sample_strobe !== 1'b1) $display("FAIL under_strobe: got %b want 1", sample_strobe); else n_pass++;
    n_checks++; if (dut.state_q !== FILL) $display("FAIL under_state: got %0d want %0d", dut.state_q, FILL); else n_pass++;
    step();
    n_checks++; if (underrun !== 1'b0) $display("FAIL under_pulse_end: got %b want 0", underrun); else n_pass++;
    repeat (8) tick(1);
    n_checks++; if (underrun_cnt !== u0 + 1) $display("FAIL under_once: got %0d want %0d", underrun_cnt, u0 + 1); else n_pass++;
    n_checks++; if (parallel_out !== 8'h80) $display("FAIL under_fill_ticks: got %h want 80", parallel_out); else n_pass++;
    push(8'hA1); push(8'hA2); push(8'hA3);
    step();
    n_checks++; if (dut.state_q !== FILL) $display("FAIL under_three_pushes: got %0d want %0d", dut.state_q, FILL); else n_pass++;
    push(8'hA4);
    step();
    n_checks++; if (dut.state_q !== RUN) $display("FAIL under_resume: got %0d want %0d", dut.state_q, RUN); else n_pass++;
    repeat (7) tick(1);
    n_checks++; if (parallel_out !== 8'h80) $display("FAIL under_resume_hold: got %h want 80", parallel_out); else n_pass++;
    tick(1);
    n_checks++; if (parallel_out !== 8'hA1) $display("FAIL under_resume_word: got %h want a1", parallel_out); else n_pass++;
  endtask

  task automatic test_disable_reset();
    repeat (3) tick(1);
    en = 1'b0;
    step();
    n_checks++; if (parallel_out !== 8'h80) $display("FAIL dis_out: got %h want 80", parallel_out); else n_pass++;
    n_checks++; if (level !== 4'd3) $display("FAIL dis_level: got %0d want 3", level); else n_pass++;
    n_checks++; if (dut.state_q !== IDLE) $display("FAIL dis_state: got %0d want %0d", dut.state_q, IDLE); else n_pass++;
    repeat (8) tick(1);
    n_checks++; if (parallel_out !== 8'h80) $display("FAIL dis_ticks_ignored: got %h want 80", parallel_out); else n_pass++;
    push(8'hB1); push(8'hB2);
    n_checks++; if (level !== 4'd5) $display("FAIL dis_level5: got %0d want 5", level); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (level !== 4'd0) $display("FAIL rst_level: got %0d want 0", level); else n_pass++;
    n_checks++; if (wr_ready !== 1'b1) $display("FAIL rst_wr_ready: got %b want 1", wr_ready); else n_pass++;
    n_checks++; if (parallel_out !== 8'h80) $display("FAIL rst_out: got %h want 80", parallel_out); else n_pass++;
    #2;
    rst = 1'b0;
    push(8'hC0);
    n_checks++; if (level !== 4'd1) $display("FAIL rst_first_write: got %0d want 1", level); else n_pass++;
  endtask

  task automatic test_full();
    en = 1'b1;
    wr_valid = 1'b1;
    for (int k = 1; k < 8; k++) begin
      wr_data = 8'hC0 + 8'(k);
      step();
    end
    n_checks++; if (level !== 4'd8) $display("FAIL full_level: got %0d want 8", level); else n_pass++;
    n_checks++; if (wr_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", wr_ready); else n_pass++;
    wr_data = 8'hAA;
    step();
    step();
    wr_valid = 1'b0;
    n_checks++; if (level !== 4'd8) $display("FAIL full_refuse: got %0d want 8", level); else n_pass++;
    n_checks++; if (wr_ready !== 1'b0) $display("FAIL full_ready_held: got %b want 0", wr_ready); else n_pass++;
    n_checks++; if (dut.state_q !== RUN) $display("FAIL full_state: got %0d want %0d", dut.state_q, RUN); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] mid [4];
    logic [7:0] tail [3];
    mid  = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    tail = '{8'hC6, 8'hC7, 8'hDD};
    repeat (7) tick(1);
    wr_data = 8'hAA; wr_valid = 1'b1; bit_tick = 1'b1;
    step();
    wr_valid = 1'b0; bit_tick = 1'b0;
    n_checks++; if (level !== 4'd7) $display("FAIL b2b_full_level: got %0d want 7", level); else n_pass++;
    n_checks++; if (parallel_out !== 8'hC0) $display("FAIL b2b_full_pop: got %h want c0", parallel_out); else n_pass++;
    n_checks++; if (wr_ready !== 1'b1) $display("FAIL b2b_ready_back: got %b want 1", wr_ready); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      repeat (8) tick(1);
      n_checks++; if (parallel_out !== mid[i]) $display("FAIL b2b_mid%0d: got %h want %h", i, parallel_out, mid[i]); else n_pass++;
    end
    n_checks++; if (level !== 4'd3) $display("FAIL b2b_level3: got %0d want 3", level); else n_pass++;
    repeat (7) tick(1);
    wr_data = 8'hDD; wr_valid = 1'b1; bit_tick = 1'b1;
    step();
    wr_valid = 1'b0; bit_tick = 1'b0;
    n_checks++; if (level !== 4'd3) $display("FAIL b2b_level_same: got %0d want 3", level); else n_pass++;
    n_checks++; if (parallel_out !== 8'hC5) $display("FAIL b2b_pop_c5: got %h want c5", parallel_out); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      repeat (8) tick(1);
      n_checks++; if (parallel_out !== tail[i]) $display("FAIL b2b_tail%0d: got %h want %h", i, parallel_out, tail[i]); else n_pass++;
    end
    repeat (7) tick(1);
    wr_data = 8'hEE; wr_valid = 1'b1; bit_tick = 1'b1;
    step();
    wr_valid = 1'b0; bit_tick = 1'b0;
    n_checks++; if (parallel_out !== 8'h80) $display("FAIL b2b_empty_out: got %h want 80", parallel_out); else n_pass++;
    n_checks++; if (underrun !== 1'b1) $display("FAIL b2b_empty_underrun: got %b want 1", underrun); else n_pass++;
    n_checks++; if (level !== 4'd1) $display("FAIL b2b_empty_push_kept: got %0d want 1", level); else n_pass++;
    n_checks++; if (dut.state_q !== FILL) $display("FAIL b2b_empty_state: got %0d want %0d", dut.state_q, FILL); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_priming();
    test_steady();
    test_underrun();
    test_disable_reset();
    test_full();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
